// File: rtl/rx_iq_fifo.sv
// rx_iq_fifo: show-ahead FIFO for decimated RX1/RX2 IQ frames.
// The receive chain writes one 96-bit frame per valid strobe. The bus side
// sees the head frame on the outputs and pops it on a rising edge of
// IQ_RX_READ_CLK (gated by IQ_RX_READ_REQ). Overrun and underrun flags are
// sticky until iq_overrun_clear.
module rx_iq_fifo #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic signed [23:0]      RX1_I_in,
  input  logic signed [23:0]      RX1_Q_in,
  input  logic signed [23:0]      RX2_I_in,
  input  logic signed [23:0]      RX2_Q_in,
  input  logic                    rx_iq_valid,
  input  logic                    IQ_RX_READ_REQ,
  input  logic                    IQ_RX_READ_CLK,
  input  logic                    iq_overrun_clear,
  output logic signed [23:0]      RX1_I,
  output logic signed [23:0]      RX1_Q,
  output logic signed [23:0]      RX2_I,
  output logic signed [23:0]      RX2_Q,
  output logic                    iq_empty,
  output logic [DEPTH_LOG2:0]     fill_level,
  output logic                    iq_overrun,
  output logic                    iq_underrun
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** DEPTH_LOG2);
  localparam logic [PW-1:0] LAST  = DEPTH - PW'(1);
  localparam logic [PW-1:0] ONE   = PW'(1);

  // Frame layout: {RX1_Q, RX1_I, RX2_Q, RX2_I}
  logic [95:0]   mem [0:(2**DEPTH_LOG2)-1];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next, count_next;
  logic          read_clk_d;
  logic          pop, full, empty_now, wr_acc, pop_acc;
  logic          overrun_set, underrun_set;
  logic [95:0]   in_frame, head_next;

  // Pop detection, write/pop acceptance, next-state pointers and next head frame
  always_comb begin
    in_frame     = {RX1_Q_in, RX1_I_in, RX2_Q_in, RX2_I_in};
    pop          = IQ_RX_READ_CLK & ~read_clk_d & IQ_RX_READ_REQ;
    full         = (count == DEPTH);
    empty_now    = (count == '0);
    pop_acc      = pop & ~empty_now;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is kept
    wr_acc       = rx_iq_valid & (~full | pop);
    overrun_set  = rx_iq_valid & full & ~pop;
    underrun_set = pop & empty_now;

    wr_ptr_next = wr_ptr;
    if (wr_acc) wr_ptr_next = (wr_ptr == LAST) ? '0 : wr_ptr + ONE;
    rd_ptr_next = rd_ptr;
    if (pop_acc) rd_ptr_next = (rd_ptr == LAST) ? '0 : rd_ptr + ONE;
    count_next = count + (wr_acc ? ONE : '0) - (pop_acc ? ONE : '0);

    // The post-edge head is the slot being written this cycle whenever the
    // read pointer lands on the write pointer, so forward the incoming frame
    head_next = '0;
    if (count_next != '0) begin
      if (wr_acc && (rd_ptr_next == wr_ptr)) head_next = in_frame;
      else                                   head_next = mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    end
  end

  // Frame storage; contents are don't-care after reset
  always_ff @(posedge clk_in) begin
    if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_frame;
  end

  // Pointers, count, edge detector, registered head outputs and sticky flags
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      read_clk_d  <= 1'b0;
      RX1_I       <= '0;
      RX1_Q       <= '0;
      RX2_I       <= '0;
      RX2_Q       <= '0;
      iq_empty    <= 1'b1;
      iq_overrun  <= 1'b0;
      iq_underrun <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      read_clk_d <= IQ_RX_READ_CLK;
      RX1_Q      <= head_next[95:72];
      RX1_I      <= head_next[71:48];
      RX2_Q      <= head_next[47:24];
      RX2_I      <= head_next[23:0];
      iq_empty   <= (count_next == '0);
      if (iq_overrun_clear) begin
        iq_overrun  <= 1'b0;
        iq_underrun <= 1'b0;
      end else begin
        if (overrun_set)  iq_overrun  <= 1'b1;
        if (underrun_set) iq_underrun <= 1'b1;
      end
    end
  end

  assign fill_level = count;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// tb_rx_iq_fifo: directed test of rx_iq_fifo with hand-derived expectations.
// Frame n carries I1=4n-3, Q1=4n-2, I2=4n-1, Q2=4n; frame 0 means "outputs zero".
module tb_rx_iq_fifo;

  logic               clk_in = 1'b0;
  logic               reset;
  logic signed [23:0] RX1_I_in, RX1_Q_in, RX2_I_in, RX2_Q_in;
  logic               rx_iq_valid, IQ_RX_READ_REQ, IQ_RX_READ_CLK, iq_overrun_clear;
  logic signed [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic               iq_empty;
  logic [5:0]         fill_level;
  logic               iq_overrun, iq_underrun;

  int errors = 0;
  int checks = 0;

  rx_iq_fifo #(.DEPTH_LOG2(5)) dut (
    .clk_in(clk_in), .reset(reset),
    .RX1_I_in(RX1_I_in), .RX1_Q_in(RX1_Q_in), .RX2_I_in(RX2_I_in), .RX2_Q_in(RX2_Q_in),
    .rx_iq_valid(rx_iq_valid), .IQ_RX_READ_REQ(IQ_RX_READ_REQ),
    .IQ_RX_READ_CLK(IQ_RX_READ_CLK), .iq_overrun_clear(iq_overrun_clear),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .iq_empty(iq_empty), .fill_level(fill_level),
    .iq_overrun(iq_overrun), .iq_underrun(iq_underrun)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [23:0] pat(input int n, input int k);
    pat = (n == 0) ? 24'd0 : 24'(4 * n - 4 + k);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs settle and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input int n, input logic rclk, input logic req);
    rx_iq_valid    = valid;
    RX1_I_in       = pat(n, 1);
    RX1_Q_in       = pat(n, 2);
    RX2_I_in       = pat(n, 3);
    RX2_Q_in       = pat(n, 4);
    IQ_RX_READ_CLK = rclk;
    IQ_RX_READ_REQ = req;
    step();
  endtask

  task automatic write_frame(input int n);
    applyStimulus(1'b1, n, 1'b0, 1'b1);
    rx_iq_valid = 1'b0;
  endtask

  // READ_CLK high one cycle, then low one cycle
  task automatic pop_pulse(input logic req);
    applyStimulus(1'b0, 0, 1'b1, req);
    applyStimulus(1'b0, 0, 1'b0, req);
  endtask

  task automatic check_head(input string tag, input int n);
    checkOutput({tag, ".RX1_I"}, 32'(RX1_I), 32'(pat(n, 1)));
    checkOutput({tag, ".RX1_Q"}, 32'(RX1_Q), 32'(pat(n, 2)));
    checkOutput({tag, ".RX2_I"}, 32'(RX2_I), 32'(pat(n, 3)));
    checkOutput({tag, ".RX2_Q"}, 32'(RX2_Q), 32'(pat(n, 4)));
  endtask

  task automatic check_status(input string tag, input int fill, input logic emp,
                              input logic ovr, input logic unr);
    checkOutput({tag, ".fill"},     32'(fill_level),  32'(fill));
    checkOutput({tag, ".empty"},    32'(iq_empty),    32'(emp));
    checkOutput({tag, ".overrun"},  32'(iq_overrun),  32'(ovr));
    checkOutput({tag, ".underrun"}, 32'(iq_underrun), 32'(unr));
  endtask

  initial begin
    reset = 1'b1;
    iq_overrun_clear = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    check_head("reset", 0);
    check_status("reset", 0, 1'b1, 1'b0, 1'b0);

    // Single write into empty FIFO appears right after the write edge
    write_frame(1);
    check_head("wr1", 1);
    check_status("wr1", 1, 1'b0, 1'b0, 1'b0);

    // Three frames, three pops
    write_frame(2);
    write_frame(3);
    check_head("wr3", 1);
    checkOutput("wr3.fill", 32'(fill_level), 32'd3);
    pop_pulse(1'b1);
    check_head("pop_a", 2);
    pop_pulse(1'b1);
    check_head("pop_b", 3);
    pop_pulse(1'b1);
    check_head("pop_c", 0);
    check_status("pop_c", 0, 1'b1, 1'b0, 1'b0);

    // 33 back-to-back writes: the last one is dropped
    for (int n = 1; n <= 33; n++) applyStimulus(1'b1, n, 1'b0, 1'b1);
    rx_iq_valid = 1'b0;
    check_head("full", 1);
    check_status("full", 32, 1'b0, 1'b1, 1'b0);
    iq_overrun_clear = 1'b1;
    step();
    iq_overrun_clear = 1'b0;
    check_status("clr", 32, 1'b0, 1'b0, 1'b0);

    // Write and pop together while full: accepted, count unchanged, no overrun
    applyStimulus(1'b1, 34, 1'b1, 1'b1);
    rx_iq_valid = 1'b0;
    check_head("full_wp", 2);
    check_status("full_wp", 32, 1'b0, 1'b0, 1'b0);
    IQ_RX_READ_CLK = 1'b0;
    step();

    // Drain: 3..32 then 34, then zero
    for (int i = 1; i <= 32; i++) begin
      pop_pulse(1'b1);
      check_head($sformatf("drain%0d", i), (i <= 30) ? i + 2 : ((i == 31) ? 34 : 0));
    end
    check_status("drained", 0, 1'b1, 1'b0, 1'b0);

    // Pop on empty
    pop_pulse(1'b1);
    check_head("under", 0);
    check_status("under", 0, 1'b1, 1'b0, 1'b1);
    iq_overrun_clear = 1'b1;
    step();
    iq_overrun_clear = 1'b0;
    checkOutput("under_clr", 32'(iq_underrun), 32'd0);

    // READ_CLK held high for 10 cycles pops once; REQ low blocks pops
    write_frame(1);
    write_frame(2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("hold.fill", 32'(fill_level), 32'd1);
    check_head("hold", 2);
    for (int i = 0; i < 3; i++) pop_pulse(1'b0);
    checkOutput("noreq.fill", 32'(fill_level), 32'd1);
    check_head("noreq", 2);
    pop_pulse(1'b1);
    check_status("noreq_end", 0, 1'b1, 1'b0, 1'b0);

    // Mid-stream reset with 17 frames and a set flag
    pop_pulse(1'b1);
    for (int n = 1; n <= 17; n++) write_frame(n);
    check_status("pre_rst", 17, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_head("mid_rst", 0);
    check_status("mid_rst", 0, 1'b1, 1'b0, 1'b0);

    // 100 simultaneous write/pop pairs around one held frame, crossing pointer wrap
    write_frame(200);
    check_head("wrap0", 200);
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 200 + i, 1'b1, 1'b1);
      rx_iq_valid = 1'b0;
      check_head($sformatf("wrap%0d", i), 200 + i);
      checkOutput($sformatf("wrap%0d.fill", i), 32'(fill_level), 32'd1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
    end
    pop_pulse(1'b1);
    check_head("wrap_end", 0);
    check_status("wrap_end", 0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
